// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle MIPS-subset control sequencer.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_I,
        S_MEM_ADDR,
        S_MEM_RD,
        S_MEM_WR,
        S_WB_R,
        S_WB_I,
        S_WB_MEM
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_SRA = 6'b000011;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [4:0] ALU_ADD = 5'b00000;
    localparam logic [4:0] ALU_SUB = 5'b00001;
    localparam logic [4:0] ALU_SLT = 5'b00111;
    localparam logic [4:0] ALU_SLL = 5'b01000;
    localparam logic [4:0] ALU_SRL = 5'b01001;
    localparam logic [4:0] ALU_SRA = 5'b01011;
    localparam logic [4:0] ALU_NOR = 5'b10001;
    localparam logic [4:0] ALU_XOR = 5'b10110;
    localparam logic [4:0] ALU_AND = 5'b11000;
    localparam logic [4:0] ALU_OR  = 5'b11110;

    localparam logic [1:0] SRCB_RT   = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       iord;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [4:0] alu_op;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       instr_done;
        logic       illegal;
        logic       mem_err;
    } ctl_t;

endpackage

// File: rtl/mc_ctl_if.sv
// Instruction-field inputs, memory handshake and datapath control outputs of mc_ctl.
interface mc_ctl_if #(parameter int CNT_W = 32);
    logic [5:0]       opCode;
    logic [5:0]       funct;
    logic             mem_ready;
    logic             PCWrite;
    logic             IorD;
    logic             IRWrite;
    logic             MemRead;
    logic             MemWrite;
    logic             ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [4:0]       ALUOp;
    logic             RegDst;
    logic             MemToReg;
    logic             RegWrite;
    logic             instr_done;
    logic             illegal;
    logic             mem_err;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  opCode, funct, mem_ready,
        output PCWrite, IorD, IRWrite, MemRead, MemWrite, ALUSrcA, ALUSrcB, ALUOp,
               RegDst, MemToReg, RegWrite, instr_done, illegal, mem_err, instr_count
    );

    modport slave (
        output opCode, funct, mem_ready,
        input  PCWrite, IorD, IRWrite, MemRead, MemWrite, ALUSrcA, ALUSrcB, ALUOp,
               RegDst, MemToReg, RegWrite, instr_done, illegal, mem_err, instr_count
    );
endinterface

// File: rtl/alu_dec.sv
// Combinational op/funct decode to ALU function, legality and shift flag; zero latency.
module alu_dec
    import mc_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output logic [4:0] alu_op,
    output logic       legal,
    output logic       is_shift
);

    always_comb begin
        alu_op   = ALU_ADD;
        legal    = 1'b0;
        is_shift = 1'b0;
        case (op)
            OP_RTYPE: begin
                legal = 1'b1;
                case (funct)
                    FN_ADD: alu_op = ALU_ADD;
                    FN_SUB: alu_op = ALU_SUB;
                    FN_AND: alu_op = ALU_AND;
                    FN_OR:  alu_op = ALU_OR;
                    FN_XOR: alu_op = ALU_XOR;
                    FN_NOR: alu_op = ALU_NOR;
                    FN_SLT: alu_op = ALU_SLT;
                    FN_SLL: begin alu_op = ALU_SLL; is_shift = 1'b1; end
                    FN_SRL: begin alu_op = ALU_SRL; is_shift = 1'b1; end
                    FN_SRA: begin alu_op = ALU_SRA; is_shift = 1'b1; end
                    default: legal = 1'b0;
                endcase
            end
            OP_ADDI: begin legal = 1'b1; alu_op = ALU_ADD; end
            OP_ANDI: begin legal = 1'b1; alu_op = ALU_AND; end
            OP_ORI:  begin legal = 1'b1; alu_op = ALU_OR;  end
            OP_XORI: begin legal = 1'b1; alu_op = ALU_XOR; end
            OP_LW, OP_SW: begin legal = 1'b1; alu_op = ALU_ADD; end
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_ctl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer; R/I/sw 4 cycles, lw 5, illegal 2.
// Stalls in FETCH/MEM_RD/MEM_WR until mem_ready, aborting to FETCH after TIMEOUT wait cycles.
module mc_ctl
    import mc_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic     clk,
    input  logic     reset_n,
    mc_ctl_if.master bus
);

    localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    state_t            state, state_nx;
    logic [5:0]        op_q, fn_q;
    logic [WAIT_W-1:0] wait_cnt;
    logic [CNT_W-1:0]  cnt;
    ctl_t              ctl, ctl_o;
    logic [5:0]        dec_op, dec_fn;
    logic [4:0]        dec_alu_op;
    logic              dec_legal, dec_shift;
    logic              waiting, timeout_hit;

    // The IR fields are only trusted live in DECODE; later phases use the latched copy.
    assign dec_op = (state == S_DECODE) ? bus.opCode : op_q;
    assign dec_fn = (state == S_DECODE) ? bus.funct  : fn_q;

    alu_dec u_alu_dec (
        .op       (dec_op),
        .funct    (dec_fn),
        .alu_op   (dec_alu_op),
        .legal    (dec_legal),
        .is_shift (dec_shift)
    );

    assign waiting = ((state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR))
                     && !bus.mem_ready;
    assign timeout_hit = (TIMEOUT != 0) && waiting && (wait_cnt == WAIT_LAST);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= S_FETCH;
            op_q     <= '0;
            fn_q     <= '0;
            wait_cnt <= '0;
            cnt      <= '0;
        end else begin
            state    <= state_nx;
            wait_cnt <= (waiting && !timeout_hit) ? wait_cnt + WAIT_W'(1) : '0;
            if (state == S_DECODE) begin
                op_q <= bus.opCode;
                fn_q <= bus.funct;
            end
            if (ctl.instr_done) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_nx = state;
        ctl      = '0;
        case (state)
            S_FETCH: begin
                ctl.mem_read  = 1'b1;
                ctl.alu_src_b = SRCB_FOUR;
                ctl.alu_op    = ALU_ADD;
                if (bus.mem_ready) begin
                    ctl.pc_write = 1'b1;
                    ctl.ir_write = 1'b1;
                    state_nx     = S_DECODE;
                end else if (timeout_hit) begin
                    ctl.mem_err = 1'b1;
                end
            end
            S_DECODE: begin
                if (!dec_legal) begin
                    ctl.illegal = 1'b1;
                    state_nx    = S_FETCH;
                end else if (bus.opCode == OP_RTYPE) begin
                    state_nx = S_EXEC_R;
                end else if ((bus.opCode == OP_LW) || (bus.opCode == OP_SW)) begin
                    state_nx = S_MEM_ADDR;
                end else begin
                    state_nx = S_EXEC_I;
                end
            end
            S_EXEC_R: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = dec_shift ? SRCB_IMM : SRCB_RT;
                ctl.alu_op    = dec_alu_op;
                state_nx      = S_WB_R;
            end
            S_EXEC_I: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_IMM;
                ctl.alu_op    = dec_alu_op;
                state_nx      = S_WB_I;
            end
            S_MEM_ADDR: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_IMM;
                ctl.alu_op    = ALU_ADD;
                state_nx      = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                ctl.mem_read = 1'b1;
                ctl.iord     = 1'b1;
                if (bus.mem_ready) begin
                    state_nx = S_WB_MEM;
                end else if (timeout_hit) begin
                    ctl.mem_err = 1'b1;
                    state_nx    = S_FETCH;
                end
            end
            S_MEM_WR: begin
                ctl.mem_write = 1'b1;
                ctl.iord      = 1'b1;
                if (bus.mem_ready) begin
                    ctl.instr_done = 1'b1;
                    state_nx       = S_FETCH;
                end else if (timeout_hit) begin
                    ctl.mem_err = 1'b1;
                    state_nx    = S_FETCH;
                end
            end
            S_WB_R: begin
                ctl.reg_write  = 1'b1;
                ctl.instr_done = 1'b1;
                state_nx       = S_FETCH;
            end
            S_WB_I: begin
                ctl.reg_write  = 1'b1;
                ctl.reg_dst    = 1'b1;
                ctl.instr_done = 1'b1;
                state_nx       = S_FETCH;
            end
            S_WB_MEM: begin
                ctl.reg_write  = 1'b1;
                ctl.reg_dst    = 1'b1;
                ctl.mem_to_reg = 1'b1;
                ctl.instr_done = 1'b1;
                state_nx       = S_FETCH;
            end
            default: state_nx = S_FETCH;
        endcase
    end

    // While reset is held every output reads zero, including the counter.
    assign ctl_o = reset_n ? ctl : '0;

    assign bus.PCWrite     = ctl_o.pc_write;
    assign bus.IorD        = ctl_o.iord;
    assign bus.IRWrite     = ctl_o.ir_write;
    assign bus.MemRead     = ctl_o.mem_read;
    assign bus.MemWrite    = ctl_o.mem_write;
    assign bus.ALUSrcA     = ctl_o.alu_src_a;
    assign bus.ALUSrcB     = ctl_o.alu_src_b;
    assign bus.ALUOp       = ctl_o.alu_op;
    assign bus.RegDst      = ctl_o.reg_dst;
    assign bus.MemToReg    = ctl_o.mem_to_reg;
    assign bus.RegWrite    = ctl_o.reg_write;
    assign bus.instr_done  = ctl_o.instr_done;
    assign bus.illegal     = ctl_o.illegal;
    assign bus.mem_err     = ctl_o.mem_err;
    assign bus.instr_count = reset_n ? cnt : '0;

endmodule

// File: tb/tb_mc_ctl.sv
// Directed per-cycle vectors for mc_ctl, built with TIMEOUT=4 so abort paths are short.
module tb_mc_ctl;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    mc_ctl_if #(.CNT_W(32)) bus ();

    mc_ctl #(.CNT_W(32), .TIMEOUT(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // {PCWrite,IorD,IRWrite,MemRead,MemWrite,ALUSrcA}, ALUSrcB, ALUOp,
    // {RegDst,MemToReg,RegWrite,instr_done,illegal,mem_err}
    typedef logic [18:0] ctl_t;

    typedef struct {
        string       name;
        bit          rst;
        bit [5:0]    op;
        bit [5:0]    fn;
        bit          rdy;
        ctl_t        exp;
        int unsigned cnt;
    } vec_t;

    ctl_t act;
    assign act = {bus.PCWrite, bus.IorD, bus.IRWrite, bus.MemRead, bus.MemWrite, bus.ALUSrcA,
                  bus.ALUSrcB, bus.ALUOp,
                  bus.RegDst, bus.MemToReg, bus.RegWrite, bus.instr_done, bus.illegal, bus.mem_err};

    int n_cmp = 0;
    int n_bad = 0;
    vec_t tbl[$];

    localparam ctl_t ZERO     = {6'b000000, 2'b00, 5'b00000, 6'b000000};
    localparam ctl_t F_RDY    = {6'b101100, 2'b01, 5'b00000, 6'b000000};
    localparam ctl_t F_WAIT   = {6'b000100, 2'b01, 5'b00000, 6'b000000};
    localparam ctl_t F_TMO    = {6'b000100, 2'b01, 5'b00000, 6'b000001};
    localparam ctl_t DEC      = {6'b000000, 2'b00, 5'b00000, 6'b000000};
    localparam ctl_t DEC_ILL  = {6'b000000, 2'b00, 5'b00000, 6'b000010};
    localparam ctl_t EX_ADD   = {6'b000001, 2'b00, 5'b00000, 6'b000000};
    localparam ctl_t EX_SUB   = {6'b000001, 2'b00, 5'b00001, 6'b000000};
    localparam ctl_t EX_SLL   = {6'b000001, 2'b10, 5'b01000, 6'b000000};
    localparam ctl_t EX_SRA   = {6'b000001, 2'b10, 5'b01011, 6'b000000};
    localparam ctl_t EX_ORI   = {6'b000001, 2'b10, 5'b11110, 6'b000000};
    localparam ctl_t MADDR    = {6'b000001, 2'b10, 5'b00000, 6'b000000};
    localparam ctl_t MRD      = {6'b010100, 2'b00, 5'b00000, 6'b000000};
    localparam ctl_t MWR_RDY  = {6'b010010, 2'b00, 5'b00000, 6'b000100};
    localparam ctl_t MWR_WAIT = {6'b010010, 2'b00, 5'b00000, 6'b000000};
    localparam ctl_t MWR_TMO  = {6'b010010, 2'b00, 5'b00000, 6'b000001};
    localparam ctl_t WB_R     = {6'b000000, 2'b00, 5'b00000, 6'b001100};
    localparam ctl_t WB_I     = {6'b000000, 2'b00, 5'b00000, 6'b101100};
    localparam ctl_t WB_MEM   = {6'b000000, 2'b00, 5'b00000, 6'b111100};

    localparam bit [5:0] G = 6'h3f;

    task automatic add_v(input string n, input bit rst, input bit [5:0] op, input bit [5:0] fn,
                         input bit rdy, input ctl_t e, input int unsigned c);
        vec_t v;
        v.name = n; v.rst = rst; v.op = op; v.fn = fn; v.rdy = rdy; v.exp = e; v.cnt = c;
        tbl.push_back(v);
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic step(input string n, input bit rst, input bit [5:0] op, input bit [5:0] fn,
                        input bit rdy, input ctl_t e, input int unsigned c);
        @(negedge clk);
        reset_n       = rst;
        bus.opCode    = op;
        bus.funct     = fn;
        bus.mem_ready = rdy;
        #1;
        n_cmp++;
        if (act !== e) begin
            n_bad++;
            $display("FAIL %s ctl: got %b want %b", n, act, e);
        end
        n_cmp++;
        if (bus.instr_count !== c) begin
            n_bad++;
            $display("FAIL %s instr_count: got %0d want %0d", n, bus.instr_count, c);
        end
    endtask

    initial begin
        reset_n       = 1'b0;
        bus.opCode    = '0;
        bus.funct     = '0;
        bus.mem_ready = 1'b0;

        add_v("rst0",      0, 0,  0,  1, ZERO,    0);
        add_v("rst1",      0, 0,  0,  1, ZERO,    0);
        add_v("add_f",     1, G,  G,  1, F_RDY,   0);
        add_v("add_d",     1, 0,  6'h20, 0, DEC,  0);
        add_v("add_x",     1, G,  G,  1, EX_ADD,  0);
        add_v("add_wb",    1, G,  G,  0, WB_R,    0);
        add_v("ill_op_f",  1, G,  G,  1, F_RDY,   1);
        add_v("ill_op_d",  1, 6'h02, 6'h20, 1, DEC_ILL, 1);
        add_v("ill_fn_f",  1, G,  G,  1, F_RDY,   1);
        add_v("ill_fn_d",  1, 0,  G,  1, DEC_ILL, 1);
        add_v("sw_f",      1, G,  G,  1, F_RDY,   1);
        add_v("sw_d",      1, 6'h2b, G, 1, DEC,   1);
        add_v("sw_a",      1, G,  G,  1, MADDR,   1);
        add_v("sw_w",      1, G,  G,  1, MWR_RDY, 1);
        add_v("sll_f",     1, G,  G,  1, F_RDY,   2);
        add_v("sll_d",     1, 0,  0,  1, DEC,     2);
        add_v("sll_x",     1, G,  G,  1, EX_SLL,  2);
        add_v("sll_wb",    1, G,  G,  1, WB_R,    2);
        add_v("sub_f",     1, G,  G,  1, F_RDY,   3);
        add_v("sub_d",     1, 0,  6'h22, 1, DEC,  3);
        add_v("sub_x",     1, G,  G,  0, EX_SUB,  3);
        add_v("sub_wb",    1, G,  G,  1, WB_R,    3);
        add_v("sra_fw",    1, G,  G,  0, F_WAIT,  4);
        add_v("sra_f",     1, G,  G,  1, F_RDY,   4);
        add_v("sra_d",     1, 0,  6'h03, 1, DEC,  4);
        add_v("sra_x",     1, G,  G,  1, EX_SRA,  4);
        add_v("sra_wb",    1, G,  G,  1, WB_R,    4);
        add_v("ori_f",     1, G,  G,  1, F_RDY,   5);
        add_v("ori_d",     1, 6'h0d, G, 1, DEC,   5);
        add_v("ori_x",     1, G,  G,  1, EX_ORI,  5);
        add_v("ori_wb",    1, G,  G,  1, WB_I,    5);
        add_v("lw_f",      1, G,  G,  1, F_RDY,   6);
        add_v("lw_d",      1, 6'h23, G, 1, DEC,   6);
        add_v("lw_a",      1, G,  G,  1, MADDR,   6);
        add_v("lw_r0",     1, G,  G,  0, MRD,     6);
        add_v("lw_r1",     1, G,  G,  0, MRD,     6);
        add_v("lw_r2",     1, G,  G,  0, MRD,     6);
        add_v("lw_r3",     1, G,  G,  1, MRD,     6);
        add_v("lw_wb",     1, G,  G,  1, WB_MEM,  6);
        add_v("post_lw_f", 1, G,  G,  1, F_RDY,   7);

        foreach (tbl[i]) begin
            step(tbl[i].name, tbl[i].rst, tbl[i].op, tbl[i].fn, tbl[i].rdy, tbl[i].exp, tbl[i].cnt);
        end

        // Reset asserted mid-store: outputs and counter read zero, then restart in FETCH.
        step("rst_sw_d",   1, 6'h2b, G, 1, DEC,      7);
        step("rst_sw_a",   1, G,  G,  1, MADDR,      7);
        step("rst_sw_w",   1, G,  G,  0, MWR_WAIT,   7);
        step("rst_hold0",  0, G,  G,  0, ZERO,       0);
        step("rst_hold1",  0, G,  G,  1, ZERO,       0);
        step("rst_rel_fw", 1, G,  G,  0, F_WAIT,     0);
        step("rst_rel_f",  1, G,  G,  1, F_RDY,      0);
        step("rst_add_d",  1, 0,  6'h20, 1, DEC,     0);
        step("rst_add_x",  1, G,  G,  1, EX_ADD,     0);
        step("rst_add_wb", 1, G,  G,  1, WB_R,       0);

        // Fetch timeout on the 4th wait cycle, then a store timeout; neither retires.
        step("tmo_f0",     1, G,  G,  0, F_WAIT,     1);
        step("tmo_f1",     1, G,  G,  0, F_WAIT,     1);
        step("tmo_f2",     1, G,  G,  0, F_WAIT,     1);
        step("tmo_f3",     1, G,  G,  0, F_TMO,      1);
        step("tmo_f_next", 1, G,  G,  1, F_RDY,      1);
        step("tmo_sw_d",   1, 6'h2b, G, 0, DEC,      1);
        step("tmo_sw_a",   1, G,  G,  0, MADDR,      1);
        step("tmo_w0",     1, G,  G,  0, MWR_WAIT,   1);
        step("tmo_w1",     1, G,  G,  0, MWR_WAIT,   1);
        step("tmo_w2",     1, G,  G,  0, MWR_WAIT,   1);
        step("tmo_w3",     1, G,  G,  0, MWR_TMO,    1);
        step("tmo_w_next", 1, G,  G,  1, F_RDY,      1);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
